// File: rtl/rsa_cfg_matmul.sv
// Output-stationary systolic matrix multiplier C = A x B with run-time R/C/K.
// Operands are skewed at the array edges, and results drain row-major over the active sub-array.
module rsa_cfg_matmul #(
  parameter int X       = 4,
  parameter int Y       = 4,
  parameter int KMAX    = 16,
  parameter int IN_LEN  = 8,
  parameter int OUT_LEN = 20,
  parameter int ROW_W   = 3,
  parameter int COL_W   = 3,
  parameter int K_W     = 5
) (
  input  logic                 clk,
  input  logic                 sys_rst_n,
  input  logic                 start,
  input  logic [ROW_W-1:0]     cfg_rows,
  input  logic [COL_W-1:0]     cfg_cols,
  input  logic [K_W-1:0]       cfg_k,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err,
  input  logic                 in_val,
  output logic                 in_rdy,
  input  logic [X*IN_LEN-1:0]  a_data,
  input  logic [Y*IN_LEN-1:0]  b_data,
  output logic                 out_val,
  input  logic                 out_rdy,
  output logic [OUT_LEN-1:0]   out_data,
  output logic [ROW_W-1:0]     out_row,
  output logic [COL_W-1:0]     out_col,
  output logic                 ovf
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COMP  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;
  localparam int unsigned FW = $clog2(X + Y);
  localparam logic signed [OUT_LEN-1:0] ACC_MAX = {1'b0, {(OUT_LEN-1){1'b1}}};
  localparam logic signed [OUT_LEN-1:0] ACC_MIN = {1'b1, {(OUT_LEN-1){1'b0}}};

  logic [1:0]       r_state;
  logic [ROW_W-1:0] r_rows, r_row;
  logic [COL_W-1:0] r_cols, r_col;
  logic [K_W-1:0]   r_k, r_beat;
  logic [FW-1:0]    r_fl;
  logic             r_busy, r_done, r_cfg_err, r_in_rdy, r_out_val, r_ovf;

  logic w_cfg_ok, w_accept, w_fire, w_hs, w_sat_any;
  logic [OUT_LEN-1:0] w_out;

  logic [IN_LEN:0] w_a_edge [X];
  logic [IN_LEN:0] w_b_edge [Y];
  logic [IN_LEN:0] w_aw [X][Y];
  logic [IN_LEN:0] w_bn [X][Y];
  logic [IN_LEN:0] w_ae [X][Y];
  logic [IN_LEN:0] w_bs [X][Y];
  logic signed [OUT_LEN-1:0] w_acc [X][Y];
  logic w_sat [X][Y];

  assign w_cfg_ok = (cfg_rows != '0) && (cfg_rows <= ROW_W'(X)) &&
                    (cfg_cols != '0) && (cfg_cols <= COL_W'(Y)) &&
                    (cfg_k != '0) && (cfg_k <= K_W'(KMAX));
  assign w_accept = (r_state == S_IDLE) && start && w_cfg_ok;
  assign w_fire   = in_val && r_in_rdy;
  assign w_hs     = r_out_val && out_rdy;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= S_IDLE;
      r_rows    <= '0;
      r_cols    <= '0;
      r_k       <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_beat    <= '0;
      r_fl      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      r_in_rdy  <= 1'b0;
      r_out_val <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      if (w_sat_any) r_ovf <= 1'b1;
      case (r_state)
        S_IDLE: if (start) begin
          if (w_cfg_ok) begin
            r_rows   <= cfg_rows;
            r_cols   <= cfg_cols;
            r_k      <= cfg_k;
            r_beat   <= '0;
            r_busy   <= 1'b1;
            r_in_rdy <= 1'b1;
            r_ovf    <= 1'b0;
            r_state  <= S_COMP;
          end else begin
            r_cfg_err <= 1'b1;
          end
        end
        S_COMP: if (w_fire) begin
          r_beat <= r_beat + 1'b1;
          if (r_beat == r_k - 1'b1) begin
            r_in_rdy <= 1'b0;
            r_fl     <= '0;
            r_state  <= S_FLUSH;
          end
        end
        // X+Y cycles lets the last skewed beat reach PE(X-1,Y-1) and settle
        S_FLUSH: if (r_fl == FW'(X + Y - 1)) begin
          r_row     <= '0;
          r_col     <= '0;
          r_out_val <= 1'b1;
          r_state   <= S_DRAIN;
        end else begin
          r_fl <= r_fl + 1'b1;
        end
        S_DRAIN: if (w_hs) begin
          if (r_col == r_cols - 1'b1) begin
            r_col <= '0;
            if (r_row == r_rows - 1'b1) begin
              r_row     <= '0;
              r_out_val <= 1'b0;
              r_done    <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= S_IDLE;
            end else begin
              r_row <= r_row + 1'b1;
            end
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Edge injection: a non-firing cycle injects a zero bubble with valid low
  for (genvar gi = 0; gi < X; gi++) begin : g_askew
    logic [IN_LEN:0] w_new;
    assign w_new = {w_fire, a_data[gi*IN_LEN +: IN_LEN] & {IN_LEN{w_fire}}};
    if (gi == 0) begin : g_direct
      assign w_a_edge[gi] = w_new;
    end else begin : g_delay
      logic [IN_LEN:0] r_sk [gi];
      always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          for (int unsigned d = 0; d < gi; d++) r_sk[d] <= '0;
        end else begin
          r_sk[0] <= w_new;
          for (int unsigned d = 1; d < gi; d++) r_sk[d] <= r_sk[d-1];
        end
      end
      assign w_a_edge[gi] = r_sk[gi-1];
    end
  end

  for (genvar gj = 0; gj < Y; gj++) begin : g_bskew
    logic [IN_LEN:0] w_new;
    assign w_new = {w_fire, b_data[gj*IN_LEN +: IN_LEN] & {IN_LEN{w_fire}}};
    if (gj == 0) begin : g_direct
      assign w_b_edge[gj] = w_new;
    end else begin : g_delay
      logic [IN_LEN:0] r_sk [gj];
      always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          for (int unsigned d = 0; d < gj; d++) r_sk[d] <= '0;
        end else begin
          r_sk[0] <= w_new;
          for (int unsigned d = 1; d < gj; d++) r_sk[d] <= r_sk[d-1];
        end
      end
      assign w_b_edge[gj] = r_sk[gj-1];
    end
  end

  for (genvar gi = 0; gi < X; gi++) begin : g_row
    for (genvar gj = 0; gj < Y; gj++) begin : g_pe
      logic [IN_LEN:0]            r_a, r_b;
      logic signed [OUT_LEN-1:0]  r_acc;
      logic signed [2*IN_LEN-1:0] w_p;
      logic signed [OUT_LEN:0]    w_s;
      logic                       w_en, w_o;

      if (gj == 0) begin : g_wedge
        assign w_aw[gi][gj] = w_a_edge[gi];
      end else begin : g_wpe
        assign w_aw[gi][gj] = w_ae[gi][gj-1];
      end
      if (gi == 0) begin : g_nedge
        assign w_bn[gi][gj] = w_b_edge[gj];
      end else begin : g_npe
        assign w_bn[gi][gj] = w_bs[gi-1][gj];
      end

      always_comb begin
        w_p  = $signed(w_aw[gi][gj][IN_LEN-1:0]) * $signed(w_bn[gi][gj][IN_LEN-1:0]);
        w_s  = $signed({r_acc[OUT_LEN-1], r_acc}) + (OUT_LEN+1)'(w_p);
        w_en = w_aw[gi][gj][IN_LEN] & w_bn[gi][gj][IN_LEN];
        w_o  = w_en & (w_s[OUT_LEN] ^ w_s[OUT_LEN-1]);
      end

      always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          r_a   <= '0;
          r_b   <= '0;
          r_acc <= '0;
        end else begin
          r_a <= w_aw[gi][gj];
          r_b <= w_bn[gi][gj];
          if (w_accept) r_acc <= '0;
          else if (w_en) r_acc <= w_o ? (w_s[OUT_LEN] ? ACC_MIN : ACC_MAX) : w_s[OUT_LEN-1:0];
        end
      end

      assign w_ae[gi][gj]  = r_a;
      assign w_bs[gi][gj]  = r_b;
      assign w_acc[gi][gj] = r_acc;
      assign w_sat[gi][gj] = w_o;
    end
  end

  // Saturation in PEs outside the active sub-array never reaches ovf
  always_comb begin
    w_sat_any = 1'b0;
    w_out     = '0;
    for (int unsigned i = 0; i < X; i++) begin
      for (int unsigned j = 0; j < Y; j++) begin
        if (w_sat[i][j] && (ROW_W'(i) < r_rows) && (COL_W'(j) < r_cols)) w_sat_any = 1'b1;
        if ((r_row == ROW_W'(i)) && (r_col == COL_W'(j))) w_out = w_acc[i][j];
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign cfg_err  = r_cfg_err;
  assign in_rdy   = r_in_rdy;
  assign out_val  = r_out_val;
  assign out_data = w_out;
  assign out_row  = r_row;
  assign out_col  = r_col;
  assign ovf      = r_ovf;

endmodule
